// File: rtl/cp0_debug_host_if.sv
// Byte-link bundle between a host (UART/JTAG bridge) and cp0_debug_host.
// master = host side, slave = cp0_debug_host.
interface cp0_debug_host_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/cp0_debug_host.sv
// Byte-command debug master for the cp0 debug port: halt, step, register read.
// Define CP0_DEBUG_DUMP_EN to add the 'D' full-register dump command.
module cp0_debug_host #(
   parameter bit HALT_ON_RESET = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   cp0_debug_host_if.slave   link,
   output logic              debug_en,
   output logic              debug_step,
   output logic [4:0]        debug_addr,
   input  logic [31:0]       debug_data
);

   localparam logic [7:0] CMD_H = 8'h48;
   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_S = 8'h53;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CH_OK = 8'h2E;
   localparam logic [7:0] CH_NO = 8'h3F;
`ifdef CP0_DEBUG_DUMP_EN
   localparam logic [7:0] CMD_D = 8'h44;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_STEP_HI,
      S_STEP_LO,
      S_CAPTURE,
      S_SEND
`ifdef CP0_DEBUG_DUMP_EN
      , S_DUMP
`endif
   } state_e;

   state_e      state_q, state_d;
   logic        en_q, en_d;
   logic        step_q, step_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        rx_ready;
   logic        tx_valid;
`ifdef CP0_DEBUG_DUMP_EN
   logic        dump_q, dump_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         en_q    <= HALT_ON_RESET;
         step_q  <= 1'b0;
         addr_q  <= 5'd0;
         shift_q <= 32'd0;
         cnt_q   <= 2'd0;
`ifdef CP0_DEBUG_DUMP_EN
         dump_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         step_q  <= step_d;
         addr_q  <= addr_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
`ifdef CP0_DEBUG_DUMP_EN
         dump_q  <= dump_d;
`endif
      end
   end

   // Reply bytes always leave from the top of shift_q, MSB first.
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      step_d  = 1'b0;
      addr_d  = addr_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
`ifdef CP0_DEBUG_DUMP_EN
      dump_d  = dump_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (link.rx_valid) begin
               shift_d = {CH_NO, 24'd0};
               cnt_d   = 2'd0;
               state_d = S_SEND;
               unique case (link.rx_data)
                  CMD_H: begin
                     en_d    = 1'b1;
                     shift_d = {CH_OK, 24'd0};
                  end
                  CMD_G: begin
                     en_d    = 1'b0;
                     shift_d = {CH_OK, 24'd0};
                  end
                  CMD_S: begin
                     if (en_q) begin
                        state_d = S_STEP_HI;
                        step_d  = 1'b1;
                     end
                  end
                  CMD_R: state_d = S_ADDR;
`ifdef CP0_DEBUG_DUMP_EN
                  CMD_D: begin
                     addr_d  = 5'd0;
                     dump_d  = 1'b1;
                     state_d = S_DUMP;
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_ADDR: begin
            if (link.rx_valid) begin
               if (link.rx_data[7:5] != 3'd0) begin
                  shift_d = {CH_NO, 24'd0};
                  cnt_d   = 2'd0;
                  state_d = S_SEND;
               end else begin
                  addr_d  = link.rx_data[4:0];
                  state_d = S_CAPTURE;
               end
            end
         end
         S_STEP_HI: state_d = S_STEP_LO;
         S_STEP_LO: begin
            shift_d = {CH_OK, 24'd0};
            cnt_d   = 2'd0;
            state_d = S_SEND;
         end
         S_CAPTURE: begin
            shift_d = debug_data;
            cnt_d   = 2'd3;
            state_d = S_SEND;
         end
`ifdef CP0_DEBUG_DUMP_EN
         S_DUMP: begin
            shift_d = debug_data;
            cnt_d   = 2'd3;
            state_d = S_SEND;
         end
`endif
         S_SEND: begin
            if (link.tx_ready) begin
               if (cnt_q != 2'd0) begin
                  shift_d = {shift_q[23:0], 8'd0};
                  cnt_d   = cnt_q - 2'd1;
               end else begin
                  state_d = S_IDLE;
`ifdef CP0_DEBUG_DUMP_EN
                  // After register 31 the dump ends with a single '.'.
                  if (dump_q) begin
                     if (addr_q == 5'd31) begin
                        dump_d  = 1'b0;
                        shift_d = {CH_OK, 24'd0};
                        state_d = S_SEND;
                     end else begin
                        addr_d  = addr_q + 5'd1;
                        state_d = S_DUMP;
                     end
                  end
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      unique case (state_q)
         S_IDLE, S_ADDR: rx_ready = rst_n;
         S_SEND:         tx_valid = 1'b1;
         default: ;
      endcase
   end

   assign link.rx_ready = rx_ready;
   assign link.tx_valid = tx_valid;
   assign link.tx_data  = shift_q[31:24];
   assign debug_en      = en_q;
   assign debug_step    = step_q;
   assign debug_addr    = addr_q;

endmodule
